// File: rtl/core_l1d_resp_if.sv
// L1D request/ack bundle between a requester (master) and a data-memory responder (slave).
interface core_l1d_resp_if;
  logic        l1d_req_val;
  logic [31:0] l1d_req_addr;
  logic [2:0]  l1d_req_cop;
  logic [2:0]  l1d_req_size;
  logic [31:0] l1d_req_wdata;
  logic        l1d_ack_ack;
  logic [31:0] l1d_ack_rdata;
  logic        l1d_ack_err;

  modport master (
    output l1d_req_val, l1d_req_addr, l1d_req_cop, l1d_req_size, l1d_req_wdata,
    input  l1d_ack_ack, l1d_ack_rdata, l1d_ack_err
  );

  modport slave (
    input  l1d_req_val, l1d_req_addr, l1d_req_cop, l1d_req_size, l1d_req_wdata,
    output l1d_ack_ack, l1d_ack_rdata, l1d_ack_err
  );
endinterface

// File: rtl/core_l1d_resp.sv
// Single-port L1D responder: one request at a time, word-organised array, ack after LATENCY cycles.
// State | meaning: IDLE - waiting for a request; WAIT - latency countdown; ACK - one-cycle completion pulse.
module core_l1d_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  core_l1d_resp_if.slave   l1d,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  cop_q, size_q;

  logic [31:0] eff_addr, eff_wdata;
  logic [2:0]  eff_cop, eff_size;
  logic        fire, err_c, we;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wd, word, sh, rd;
  logic        unused_bits;

  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    unique case (state)
      IDLE: if (l1d.l1d_req_val) begin
        accept    = 1'b1;
        cnt_nxt   = 4'(LATENCY - 1);
        state_nxt = (LATENCY == 1) ? ACK : WAIT;
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY=1 the access edge is also the acceptance edge, so use live inputs in IDLE.
  assign eff_addr  = (state == IDLE) ? l1d.l1d_req_addr  : addr_q;
  assign eff_wdata = (state == IDLE) ? l1d.l1d_req_wdata : wdata_q;
  assign eff_cop   = (state == IDLE) ? l1d.l1d_req_cop   : cop_q;
  assign eff_size  = (state == IDLE) ? l1d.l1d_req_size  : size_q;

  assign fire  = (state_nxt == ACK);
  assign idx   = eff_addr[AW+1:2];
  assign err_c = eff_cop[2] || (eff_size > 3'd2) ||
                 ((eff_size == 3'd1) && eff_addr[0]) ||
                 ((eff_size == 3'd2) && (eff_addr[1:0] != 2'b00));
  assign we    = fire && !rst && eff_cop[0] && !err_c;
  assign unused_bits = ^{eff_addr[31:AW+2], eff_cop[1]};

  always_comb begin
    be = 4'b0000;
    wd = 32'h0;
    unique case (eff_size)
      3'd0: begin
        be = 4'b0001 << eff_addr[1:0];
        wd = {4{eff_wdata[7:0]}};
      end
      3'd1: begin
        be = eff_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{eff_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = eff_wdata;
      end
    endcase
  end

  assign word = mem[idx];
  assign sh   = word >> {eff_addr[1:0], 3'b000};

  always_comb begin
    rd = word;
    unique case (eff_size)
      3'd0:    rd = {24'h0, sh[7:0]};
      3'd1:    rd = {16'h0, sh[15:0]};
      default: rd = word;
    endcase
  end

  // Array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= 4'd0;
      addr_q            <= 32'h0;
      wdata_q           <= 32'h0;
      cop_q             <= 3'd0;
      size_q            <= 3'd0;
      busy              <= 1'b0;
      l1d.l1d_ack_ack   <= 1'b0;
      l1d.l1d_ack_err   <= 1'b0;
      l1d.l1d_ack_rdata <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q  <= l1d.l1d_req_addr;
        wdata_q <= l1d.l1d_req_wdata;
        cop_q   <= l1d.l1d_req_cop;
        size_q  <= l1d.l1d_req_size;
      end
      busy              <= (state_nxt != IDLE);
      l1d.l1d_ack_ack   <= fire;
      l1d.l1d_ack_err   <= fire && err_c;
      l1d.l1d_ack_rdata <= (fire && !err_c && !eff_cop[0]) ? rd : 32'h0;
    end
  end
endmodule

// File: tb/tb_core_l1d_resp.sv
// Bench for core_l1d_resp: four instances with different DEPTH/LATENCY, table vectors plus corner sequences.
module tb_core_l1d_resp;
  localparam int LATS   [4] = '{2, 1, 4, 15};
  localparam int DEPTHS [4] = '{1024, 16, 1024, 1024};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst, val, ack, err, busy;
  logic [31:0] addr [4];
  logic [31:0] wdata [4];
  logic [31:0] rdata [4];
  logic [2:0]  cop [4];
  logic [2:0]  size [4];

  core_l1d_resp_if bus [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign bus[g].l1d_req_val   = val[g];
    assign bus[g].l1d_req_addr  = addr[g];
    assign bus[g].l1d_req_cop   = cop[g];
    assign bus[g].l1d_req_size  = size[g];
    assign bus[g].l1d_req_wdata = wdata[g];
    assign ack[g]   = bus[g].l1d_ack_ack;
    assign err[g]   = bus[g].l1d_ack_err;
    assign rdata[g] = bus[g].l1d_ack_rdata;
    core_l1d_resp #(.DEPTH_WORDS(DEPTHS[g]), .LATENCY(LATS[g])) u_dut (
      .clk  (clk),
      .rst  (rst[g]),
      .l1d  (bus[g]),
      .busy (busy[g])
    );
  end

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    string       name;
    logic [2:0]  cop;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  exp_t sbq[$];
  int   tests = 0;
  int   failed = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic check_ack(input int d, input int lat);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("unexpected_ack", 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    chk({e.name, "_lat"},   32'(lat), 32'(LATS[d]));
    chk({e.name, "_rdata"}, rdata[d], e.rdata);
    chk({e.name, "_err"},   {31'd0, err[d]}, {31'd0, e.err});
  endtask

  task automatic run_req(input int d, input vec_t v);
    exp_t e;
    int   k, busy_n;
    bit   seen;
    e.name = v.name; e.rdata = v.rdata; e.err = v.err;
    sbq.push_back(e);
    @(negedge clk);
    val[d] = 1'b1; cop[d] = v.cop; size[d] = v.size; addr[d] = v.addr; wdata[d] = v.wdata;
    k = 0; busy_n = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (busy[d]) busy_n++;
      if (ack[d]) begin
        seen = 1'b1;
        check_ack(d, k);
        val[d] = 1'b0;
        cop[d] = 3'b111; addr[d] = 32'hFFFF_FFFF; wdata[d] = 32'hFFFF_FFFF;
      end
    end
    if (!seen) begin
      chk({v.name, "_timeout"}, 32'd1, 32'd0);
      void'(sbq.pop_front());
      val[d] = 1'b0;
    end
    chk({v.name, "_busy_cycles"}, 32'(busy_n), 32'(LATS[d]));
    @(negedge clk);
    chk({v.name, "_ack_pulse"}, {31'd0, ack[d]}, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    bit   seen;
    rst = 4'hF; val = 4'h0;
    for (int i = 0; i < 4; i++) begin
      addr[i] = 32'h0; wdata[i] = 32'h0; cop[i] = 3'd0; size[i] = 3'd0;
    end

    vecs = '{
      '{"w_word_40",    3'b001, 3'b010, 32'h40, 32'hDEADBEEF, 32'h0,        1'b0},
      '{"r_word_40",    3'b000, 3'b010, 32'h40, 32'h0,        32'hDEADBEEF, 1'b0},
      '{"w_byte_41",    3'b001, 3'b000, 32'h41, 32'hFFFFFF11, 32'h0,        1'b0},
      '{"w_half_42",    3'b001, 3'b001, 32'h42, 32'hFFFF2233, 32'h0,        1'b0},
      '{"r_word_40b",   3'b000, 3'b010, 32'h40, 32'h0,        32'h223311EF, 1'b0},
      '{"r_byte_43",    3'b000, 3'b000, 32'h43, 32'h0,        32'h00000022, 1'b0},
      '{"nc_r_half_42", 3'b010, 3'b001, 32'h42, 32'h0,        32'h00002233, 1'b0},
      '{"nc_w_word_44", 3'b011, 3'b010, 32'h44, 32'h0BADF00D, 32'h0,        1'b0},
      '{"w_half_45",    3'b001, 3'b001, 32'h45, 32'hFFFFFFFF, 32'h0,        1'b1},
      '{"r_word_42",    3'b000, 3'b010, 32'h42, 32'h0,        32'h0,        1'b1},
      '{"w_size7_44",   3'b001, 3'b111, 32'h44, 32'hFFFFFFFF, 32'h0,        1'b1},
      '{"cop4_44",      3'b100, 3'b010, 32'h44, 32'hFFFFFFFF, 32'h0,        1'b1},
      '{"r_word_44",    3'b000, 3'b010, 32'h44, 32'h0,        32'h0BADF00D, 1'b0},
      '{"r_wrap_1044",  3'b000, 3'b010, 32'h1044, 32'h0,      32'h0BADF00D, 1'b0}
    };

    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++)
      chk($sformatf("reset_outs_%0d", d), {rdata[d][30:0] | {30'd0, ack[d]}}, 32'd0);
    rst = 4'h0;
    @(negedge clk);
    for (int d = 0; d < 4; d++)
      chk($sformatf("idle_outs_%0d", d), {28'd0, ack[d], busy[d], err[d], |rdata[d]}, 32'd0);

    foreach (vecs[i]) run_req(0, vecs[i]);

    // Back-to-back with val held, LATENCY=1, DEPTH=16 so 0x40 aliases 0x0.
    sbq.push_back('{"b2b_w", 32'h0, 1'b0});
    sbq.push_back('{"b2b_r", 32'hA5A5A5A5, 1'b0});
    @(negedge clk);
    val[1] = 1'b1; cop[1] = 3'b001; size[1] = 3'b010; addr[1] = 32'h0; wdata[1] = 32'hA5A5A5A5;
    @(negedge clk);
    chk("b2b_ack_c1", {31'd0, ack[1]}, 32'd1);
    if (ack[1]) check_ack(1, 1);
    cop[1] = 3'b000; addr[1] = 32'h40; wdata[1] = 32'h0;
    @(negedge clk);
    chk("b2b_ack_c2", {31'd0, ack[1]}, 32'd0);
    chk("b2b_busy_c2", {31'd0, busy[1]}, 32'd0);
    @(negedge clk);
    chk("b2b_ack_c3", {31'd0, ack[1]}, 32'd1);
    if (ack[1]) check_ack(1, 1);
    val[1] = 1'b0;
    @(negedge clk);

    // Reset in cycle 2 of a LATENCY=4 write drops it.
    v = '{"lat4_seed", 3'b001, 3'b010, 32'h8, 32'h01020304, 32'h0, 1'b0};
    run_req(2, v);
    @(negedge clk);
    val[2] = 1'b1; cop[2] = 3'b001; size[2] = 3'b010; addr[2] = 32'h8; wdata[2] = 32'h12345678;
    @(negedge clk);
    chk("rst_mid_busy_c1", {31'd0, busy[2]}, 32'd1);
    @(negedge clk);
    rst[2] = 1'b1; val[2] = 1'b0;
    #1;
    chk("rst_mid_outs", {28'd0, ack[2], busy[2], err[2], |rdata[2]}, 32'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack[2] || busy[2]) seen = 1'b1;
    end
    chk("rst_mid_no_ack", {31'd0, seen}, 32'd0);
    v = '{"lat4_reread", 3'b000, 3'b010, 32'h8, 32'h0, 32'h01020304, 1'b0};
    run_req(2, v);

    // LATENCY=15 boundary.
    v = '{"lat15_w", 3'b001, 3'b010, 32'h100, 32'hCAFEF00D, 32'h0, 1'b0};
    run_req(3, v);
    v = '{"lat15_r", 3'b000, 3'b010, 32'h100, 32'h0, 32'hCAFEF00D, 1'b0};
    run_req(3, v);

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
